// File: rtl/ldlt_fwd_sub_if.sv
// Handshake bundle for the LDLT forward-substitution stage: RHS load, factor
// stream from the LDLT core, and per-row y/D results.
interface ldlt_fwd_sub_if #(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1
);
  localparam int N  = 6 * NODE_NUM;
  localparam int IW = $clog2(N);

  logic                       i_start;
  logic                       i_b_valid;
  logic signed [DATA_LEN-1:0] i_b_data;
  logic                       i_valid;
  logic signed [DATA_LEN-1:0] i_data;
  logic                       o_valid;
  logic signed [DATA_LEN-1:0] o_y;
  logic signed [DATA_LEN-1:0] o_d;
  logic [IW-1:0]              o_idx;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    output i_start, i_b_valid, i_b_data, i_valid, i_data,
    input  o_valid, o_y, o_d, o_idx, o_busy, o_done
  );

  modport slave (
    input  i_start, i_b_valid, i_b_data, i_valid, i_data,
    output o_valid, o_y, o_d, o_idx, o_busy, o_done
  );
endinterface

// File: rtl/ldlt_fwd_sub.sv
// Forward substitution L*y = b on a row-major lower-triangular factor stream
// (unit L diagonal implied; diagonal words carry D_ii and are passed through).
module ldlt_fwd_sub #(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1,
  parameter int FRACTION = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ldlt_fwd_sub_if.slave bus
);
  localparam int N  = 6 * NODE_NUM;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD_B, FACTOR, DONE} state_t;

  state_t                     state;
  logic [IW-1:0]              k, row, col;
  logic signed [DATA_LEN-1:0] acc;
  logic signed [DATA_LEN-1:0] b_mem [N];
  logic signed [DATA_LEN-1:0] y_mem [N];

  logic                         b_acc, f_acc, diag;
  logic signed [DATA_LEN-1:0]   acc_cur, term;
  logic signed [2*DATA_LEN-1:0] prod;

  assign b_acc = (state == LOAD_B) && bus.i_b_valid;
  assign f_acc = (state == FACTOR) && bus.i_valid;
  assign diag  = (col == row);

  // First word of a row seeds the running sum from b[row].
  assign acc_cur = (col == '0) ? b_mem[row] : acc;
  assign prod    = (2*DATA_LEN)'(bus.i_data) * (2*DATA_LEN)'(y_mem[col]);
  assign term    = DATA_LEN'(prod >>> FRACTION);

  assign bus.o_busy = (state != IDLE);

  // Storage is not reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (b_acc)         b_mem[k]   <= bus.i_b_data;
    if (f_acc && diag) y_mem[row] <= acc_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      row         <= '0;
      col         <= '0;
      acc         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_done  <= 1'b0;
      bus.o_y     <= '0;
      bus.o_d     <= '0;
      bus.o_idx   <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_done  <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          state <= LOAD_B;
          k     <= '0;
          row   <= '0;
          col   <= '0;
        end
        LOAD_B: if (bus.i_b_valid) begin
          if (k == LAST) state <= FACTOR;
          else           k     <= k + 1'b1;
        end
        FACTOR: if (bus.i_valid) begin
          if (diag) begin
            bus.o_valid <= 1'b1;
            bus.o_y     <= acc_cur;
            bus.o_d     <= bus.i_data;
            bus.o_idx   <= row;
            col         <= '0;
            if (row == LAST) begin
              state      <= DONE;
              bus.o_done <= 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= acc_cur - term;
            col <= col + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldlt_fwd_sub.sv
// Directed bench for ldlt_fwd_sub: reference forward substitution in plain
// integer arithmetic, checked against every DUT output cycle.
module tb_ldlt_fwd_sub;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldlt_fwd_sub_if #(.DATA_LEN(32), .NODE_NUM(1)) bus ();
  ldlt_fwd_sub #(.DATA_LEN(32), .NODE_NUM(1), .FRACTION(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {int y; int d; int idx;} row_t;

  int   n_chk = 0, n_fail = 0;
  int   b_v [N];
  int   l_v [N][N];
  int   d_v [N];
  int   exp_y [N];
  int   cap_y [N];
  int   ref_y [N];
  row_t exp_q [$];
  row_t e;
  int   vcnt;
  bit   done_seen;
  int   last_y, last_d, last_idx;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // y[i] = b[i] - sum_j trunc((L_ij * y[j]) / 2^16), 32-bit wraparound.
  function automatic void model();
    int     acc;
    longint p;
    for (int i = 0; i < N; i++) begin
      acc = b_v[i];
      for (int j = 0; j < i; j++) begin
        p   = longint'(l_v[i][j]) * longint'(exp_y[j]);
        acc = acc - int'(p >>> 16);
      end
      exp_y[i] = acc;
    end
  endfunction

  function automatic void set_identity();
    for (int i = 0; i < N; i++) begin
      b_v[i] = (i + 1) << 16;
      d_v[i] = 32'h10000;
      for (int j = 0; j < N; j++) l_v[i][j] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last_y = 0; last_d = 0; last_idx = 0;
    end else begin
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: got idx %0d expected no output", bus.o_idx);
        end else begin
          e = exp_q.pop_front();
          check("o_y", bus.o_y, e.y);
          check("o_d", bus.o_d, e.d);
          check("o_idx", bus.o_idx, e.idx);
        end
        if (bus.o_idx < N) cap_y[bus.o_idx] = bus.o_y;
        vcnt++;
        last_y = bus.o_y; last_d = bus.o_d; last_idx = bus.o_idx;
      end else begin
        check("hold_y", bus.o_y, last_y);
        check("hold_d", bus.o_d, last_d);
        check("hold_idx", bus.o_idx, last_idx);
      end
      if (bus.o_done) begin
        done_seen = 1'b1;
        check("done_with_valid", bus.o_valid, 1);
        check("done_idx", bus.o_idx, N - 1);
      end
    end
  end

  task automatic idle_gap(input int gap);
    int n;
    n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One solve: gap = max idle cycles between words, abort_at = factor word
  // index at which reset is applied (-1 none), start_mid = pulse i_start in FACTOR.
  task automatic run(input int gap, input int abort_at, input bit start_mid);
    int w, npush;
    model();
    npush = 0;
    for (int i = 0; i < N; i++)
      if (abort_at < 0 || (i * (i + 1) / 2 + i) < abort_at) begin
        exp_q.push_back('{exp_y[i], d_v[i], i});
        npush++;
      end
    vcnt = 0; done_seen = 1'b0;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("busy_after_start", bus.o_busy, 1);
    for (int i = 0; i < N; i++) begin
      idle_gap(gap);
      bus.i_b_valid = 1'b1; bus.i_b_data = b_v[i];
      @(posedge clk); #1;
      bus.i_b_valid = 1'b0;
    end
    w = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= i; j++) begin
        if (w == abort_at) begin
          rst_n = 1'b0; bus.i_valid = 1'b0;
          #1;
          check("rst_valid", bus.o_valid, 0);
          check("rst_busy", bus.o_busy, 0);
          check("rst_y", bus.o_y, 0);
          check("rst_idx", bus.o_idx, 0);
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          check("abort_rows", vcnt, npush);
          check("abort_queue_empty", exp_q.size(), 0);
          exp_q.delete();
          return;
        end
        idle_gap(gap);
        bus.i_valid = 1'b1;
        bus.i_data  = (j == i) ? d_v[i] : l_v[i][j];
        if (start_mid && w == 2) bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_start = 1'b0;
        w++;
      end
    for (int t = 0; t < 20 && !done_seen; t++) @(posedge clk);
    check("done_seen", done_seen, 1);
    @(posedge clk); #1;
    check("valid_count", vcnt, N);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", bus.o_busy, 0);
    exp_q.delete();
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_b_valid = 1'b0; bus.i_b_data = '0;
    bus.i_valid = 1'b0; bus.i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", bus.o_valid, 0);
    check("reset_done", bus.o_done, 0);
    check("reset_busy", bus.o_busy, 0);
    check("reset_y", bus.o_y, 0);
    check("reset_d", bus.o_d, 0);
    check("reset_idx", bus.o_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity factor: y = b.
    set_identity();
    model();
    for (int i = 0; i < N; i++) check("model_identity", exp_y[i], (i + 1) << 16);
    run(0, -1, 1'b0);

    // Coupling: y1 = 3.0 - 0.5*2.0 = 2.0.
    set_identity();
    b_v[0] = 32'h20000; b_v[1] = 32'h30000; l_v[1][0] = 32'h8000;
    model();
    check("model_coupling", exp_y[1], 32'h20000);
    run(0, -1, 1'b0);

    // Truncation toward -inf: (-1 * 0x8000) >>> 16 = -1.
    set_identity();
    b_v[0] = 32'h8000; b_v[1] = 32'h30000; l_v[1][0] = -1;
    model();
    check("model_trunc_neg", exp_y[1], 32'h30001);
    run(0, -1, 1'b0);
    l_v[1][0] = 1;
    model();
    check("model_trunc_pos", exp_y[1], 32'h30000);
    run(0, -1, 1'b0);

    // Dense matrix, gapless then stalled; results must be identical.
    for (int i = 0; i < N; i++) begin
      b_v[i] = int'($urandom);
      d_v[i] = int'($urandom);
      for (int j = 0; j < N; j++) l_v[i][j] = int'($urandom);
    end
    run(0, -1, 1'b0);
    ref_y = cap_y;
    run(3, -1, 1'b0);
    for (int i = 0; i < N; i++) check("stall_identical", cap_y[i], ref_y[i]);

    // i_start during FACTOR is ignored.
    run(1, -1, 1'b1);

    // Reset at the 10th factor word, then a clean identity run.
    set_identity();
    run(0, 9, 1'b0);
    @(posedge clk); #1;
    run(0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ldlt_fwd_sub.md
LDLT_FWD_SUB -- requirements
Module: ldlt_fwd_sub

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, word width of all data ports.
REQ-002 SHALL have parameter NODE_NUM, default 1, matrix dimension N = 6*NODE_NUM.
REQ-003 SHALL have parameter FRACTION, default 16, fractional bits of signed fixed-point data.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_start  input  1  one-cycle start pulse.
REQ-007 SHALL have port i_b_valid  input  1  RHS word valid.
REQ-008 SHALL have port i_b_data  input  DATA_LEN  signed RHS element b_i.
REQ-009 SHALL have port i_valid  input  1  factor word valid, driven from LDLT o_valid.
REQ-010 SHALL have port i_data  input  DATA_LEN  signed factor word, driven from LDLT o_data.
REQ-011 SHALL have port o_valid  output  1  result valid, one-cycle pulse per row.
REQ-012 SHALL have port o_y  output  DATA_LEN  signed y_i of L*y = b.
REQ-013 SHALL have port o_d  output  DATA_LEN  signed D_ii passed through.
REQ-014 SHALL have port o_idx  output  $clog2(N)  row index i of o_y/o_d.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse after last row.

Function
REQ-017 SHALL implement FSM IDLE, LOAD_B, FACTOR, DONE.
REQ-018 IDLE: i_start=1 -> LOAD_B, row/col counters cleared; i_start ignored in all other states.
REQ-019 LOAD_B: each cycle with i_b_valid=1 stores i_b_data into b[k], k=0..N-1; after k=N-1 accepted -> FACTOR.
REQ-020 FACTOR: factor stream is lower triangle incl. diagonal, row-major: (0,0),(1,0),(1,1),(2,0),(2,1),(2,2)...; N(N+1)/2 words total; unit diagonal of L implied.
REQ-021 Cycles with valid low SHALL stall counters and accumulator without loss; i_b_valid ignored outside LOAD_B, i_valid ignored outside FACTOR.
REQ-022 Row start: accumulator = b[i]; off-diagonal word L_ij (j<i): acc <= acc - ((L_ij * y[j]) >>> FRACTION).
REQ-023 Product SHALL be full 2*DATA_LEN signed, arithmetic right shift (truncate toward -inf), low DATA_LEN bits used; subtraction wraps two's complement, no saturation.
REQ-024 Diagonal word (j=i): y[i] <= acc (including all prior off-diagonal terms), next cycle o_valid=1, o_y=y[i], o_d=i_data, o_idx=i.
REQ-025 o_y/o_d/o_idx SHALL hold last value while o_valid=0.
REQ-026 After diagonal of row N-1 accepted -> DONE; DONE asserts o_done one cycle (same cycle as last o_valid) -> IDLE.
REQ-027 Row 0 SHALL consist solely of its diagonal word; y[0]=b[0].
REQ-028 Block SHALL accept a new i_start the cycle after DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, o_valid=0, o_done=0, o_busy=0, o_y=0, o_d=0, o_idx=0, counters 0.
REQ-030 Reset mid-LOAD_B or mid-FACTOR SHALL discard partial work; b/y storage need not be cleared.

Verification
REQ-031 Identity: N=6, b=1.0..6.0 (0x10000..0x60000), all L_ij=0, D_ii=0x10000 -> six o_valid pulses, o_y=b_i, o_d=0x10000, o_idx 0..5, o_done with last.
REQ-032 Coupling: b0=0x20000, b1=0x30000, L_10=0x8000 (0.5), others 0 -> o_y[1]=0x20000.
REQ-033 Truncation: y0=0x8000, L_10=0xFFFFFFFF (-1 LSB) -> product >>> 16 = -1 -> o_y[1]=b1+1; L_10=1 -> o_y[1]=b1.
REQ-034 Stalls: random i_b_valid/i_valid gaps of 0-3 cycles -> results bit-identical to gapless run, o_valid count = 6.
REQ-035 Reset at 10th factor word then restart with REQ-031 stimulus -> no stale o_valid, correct six results.
REQ-036 i_start pulsed during FACTOR -> ignored, run completes unchanged.
